// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with valid, stall/flush, write-back
// select, and optional retire counter (enable with macro MEM_WB_RETIRE_CNT_EN).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   stall, flush        hazard-unit hold / bubble insertion (flush wins)
//   in_*                MEM-stage instruction fields
//   out_*               registered stage fields
//   wb_en, wb_data      register-file write port (from stage registers only)
//   retire_count        retired instruction count (MEM_WB_RETIRE_CNT_EN only)
module mem_wb_stage #(
    parameter int DATA_W     = 20,
    parameter int OPCODE_W   = 4,
    parameter int REG_ADDR_W = 3,
    parameter int ZERO_REG   = 1,
    parameter int COUNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [OPCODE_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_mem_data,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    output logic                  out_valid,
    output logic [OPCODE_W-1:0]   out_opcode,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_mem_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  wb_en,
    output logic [DATA_W-1:0]     wb_data
`ifdef MEM_WB_RETIRE_CNT_EN
    ,
    output logic [COUNT_W-1:0]    retire_count
`endif
);

    logic reg_write;
    logic mem_to_reg;
    logic rd_writable;

    // On flush only the control bits are cleared; data fields hold, since
    // nothing downstream looks at them while valid is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_opcode     <= '0;
            out_alu_result <= '0;
            out_mem_data   <= '0;
            out_rd         <= '0;
            reg_write      <= 1'b0;
            mem_to_reg     <= 1'b0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            reg_write      <= 1'b0;
        end else if (!stall) begin
            out_valid      <= in_valid;
            out_opcode     <= in_opcode;
            out_alu_result <= in_alu_result;
            out_mem_data   <= in_mem_data;
            out_rd         <= in_rd;
            reg_write      <= in_reg_write;
            mem_to_reg     <= in_mem_to_reg;
        end
    end

    assign rd_writable = (ZERO_REG == 0) || (out_rd != '0);
    assign wb_en       = out_valid & reg_write & rd_writable;
    assign wb_data     = mem_to_reg ? out_mem_data : out_alu_result;

`ifdef MEM_WB_RETIRE_CNT_EN
    // The instruction in WB has committed when it leaves the stage, so a
    // flush of the incoming slot does not stop it being counted.
    always_ff @(posedge clock) begin
        if (reset) begin
            retire_count <= '0;
        end else if (!stall && out_valid) begin
            retire_count <= retire_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM/WB pipeline register for the pipelined processor, sitting between data memory and the register file. Unlike a plain MEM/WB register, it carries a valid bit, destination register and write-back controls, honours stall and flush from the hazard unit, and performs the write-back select (ALU result vs. memory data). It drives the register-file write port and the forwarding unit directly. An optional retired-instruction counter is compiled in by macro.

## Interface
Parameters:
- DATA_W, 20, width of ALU result, memory data and write-back data
- OPCODE_W, 4, opcode width
- REG_ADDR_W, 3, register-file address width
- ZERO_REG, 1, when 1 register 0 is hardwired: writes to rd==0 are suppressed
- COUNT_W, 16, retire counter width (used only with MEM_WB_RETIRE_CNT_EN)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  replace incoming instruction with a bubble
- in_valid  in  1  MEM-stage instruction valid
- in_opcode  in  OPCODE_W  MEM-stage opcode
- in_alu_result  in  DATA_W  ALU result from EX/MEM
- in_mem_data  in  DATA_W  data-memory read data
- in_rd  in  REG_ADDR_W  destination register
- in_reg_write  in  1  instruction writes the register file
- in_mem_to_reg  in  1  1 selects memory data, 0 selects ALU result
- out_valid  out  1  registered valid
- out_opcode  out  OPCODE_W  registered opcode
- out_alu_result  out  DATA_W  registered ALU result
- out_mem_data  out  DATA_W  registered memory data
- out_rd  out  REG_ADDR_W  registered destination
- wb_en  out  1  register-file write enable
- wb_data  out  DATA_W  register-file write data
- retire_count  out  COUNT_W  retired instructions (only with MEM_WB_RETIRE_CNT_EN)

## Operation
- Stage registers: valid, opcode, alu_result, mem_data, rd, reg_write, mem_to_reg.
- Per rising edge, priority reset > flush > stall > load:
  - reset: every stage register cleared to 0.
  - flush: valid, reg_write cleared to 0; other fields are don't-care and may load or hold.
  - stall (flush=0): all registers hold.
  - otherwise: all registers load from in_*.
- flush with stall both 1: flush wins; stage becomes a bubble.
- wb_en = out_valid & reg_write & (ZERO_REG==0 | out_rd!=0), combinational from stage registers.
- wb_data = mem_to_reg ? out_mem_data : out_alu_result, combinational; no width change.
- in_reg_write/in_mem_to_reg with in_valid=0 are loaded but have no effect (wb_en gated by valid).
- While stalled with wb_en=1, the same write is repeated each cycle; harmless (idempotent).

## Timing
- Latency: 1 cycle from in_* to out_*, wb_en, wb_data.
- Reset values: all out_* 0, wb_en 0, wb_data 0, retire_count 0.
- wb_en/wb_data valid from just after the edge that loads the stage; register file samples at the following edge.
- No combinational path from any in_* to any output.

## Configuration
- MEM_WB_RETIRE_CNT_EN defined: retire_count implemented. At each edge with reset=0, stall=0 and out_valid=1 (instruction leaving WB) it increments by 1, wrapping from 2^COUNT_W−1 to 0. Flush does not inhibit the increment (the outgoing instruction has already committed). reset clears it to 0.
- Not defined: retire_count port and counter absent; COUNT_W unused.

## Test plan
- Reset: drive all in_* nonzero, assert reset one edge -> all outputs 0, wb_en 0.
- Load/select: in_valid=1, in_rd=5, in_reg_write=1, in_alu_result=0x00ABC, in_mem_data=0x12345, in_mem_to_reg=0 -> next cycle wb_en=1, wb_data=0x00ABC; repeat with in_mem_to_reg=1 -> wb_data=0x12345.
- Stall: load rd=5, then stall=1 for 3 cycles with different inputs -> outputs unchanged for 3 cycles, new inputs appear one cycle after stall drops.
- Flush priority: stall=1 and flush=1 together with valid instruction in stage -> next cycle out_valid=0, wb_en=0.
- Zero register: ZERO_REG=1, in_rd=0, in_reg_write=1, in_valid=1 -> wb_en=0; with ZERO_REG=0 -> wb_en=1.
- Counter (macro defined, COUNT_W=4): 17 valid unstalled instructions -> retire_count=1 after wrap; stalled cycles do not increment.
